// File: rtl/clk_en_pkg.sv
// Shared definitions for the master-clock enable monitor: FSM encoding,
// counter widths and the NTSC enable dividers used by the enable generator.
package clk_en_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRAIN   = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_e;

    localparam int CPU_CNT_W       = 5;
    localparam int PPU_CNT_W       = 4;
    localparam int DEF_CPU_CLK_DIV = 12;
    localparam int DEF_PPU_CLK_DIV = 4;

endpackage

// File: rtl/en_period_checker.sv
// Period checker for one single-cycle enable: tracks cycles since the last
// pulse and flags pulses that arrive early or fail to arrive on time.
module en_period_checker
    import clk_en_pkg::*;
#(
    parameter int DIV   = DEF_PPU_CLK_DIV,
    parameter int CNT_W = PPU_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_seen,
    output logic [CNT_W-1:0] cnt,
    output logic             seen,
    output logic             early,
    output logic             late
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;

    // cnt is the count for the current cycle (0 on a pulse); cnt_q is last cycle's.
    always_comb begin
        early = en && (cnt_q < LAST);
        late  = !en && (cnt_q == LAST);
        if (en)
            cnt_d = '0;
        else if (cnt_q == LAST)
            cnt_d = LAST;
        else
            cnt_d = cnt_q + 1'b1;
        seen_d = clr_seen ? 1'b0 : (seen_q | en);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
        end
    end

    assign cnt  = cnt_d;
    assign seen = seen_q;

endmodule

// File: rtl/clk_en_monitor.sv
// Watches the CPU/PPU clock enables for cadence and mutual phase, reports a
// lock indication and sticky faults for loss of an established lock.
module clk_en_monitor
    import clk_en_pkg::*;
#(
    parameter int CPU_CLK_DIV = DEF_CPU_CLK_DIV,
    parameter int PPU_CLK_DIV = DEF_PPU_CLK_DIV,
    parameter int LOCK_COUNT  = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk_mst,
    input  logic                 rst_mst_n,
    input  logic                 clk_en_cpu,
    input  logic                 clk_en_ppu,
    input  logic                 mon_clear,
    output logic                 locked,
    output logic                 err_cpu_period,
    output logic                 err_ppu_period,
    output logic                 err_phase,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [3:0]           phase_offset
);

    if (CPU_CLK_DIV < 2 || CPU_CLK_DIV > 32 || PPU_CLK_DIV < 2 || PPU_CLK_DIV > 16 ||
        (CPU_CLK_DIV % PPU_CLK_DIV) != 0 || LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_param_err
        $error("clk_en_monitor: illegal divider or lock-count parameters");
    end

    localparam logic [3:0] GOOD_LAST = 4'(LOCK_COUNT - 1);

    logic [CPU_CNT_W-1:0] cpu_cnt;
    logic [PPU_CNT_W-1:0] ppu_cnt;
    logic cpu_seen, cpu_early, cpu_late, ppu_seen, ppu_early, ppu_late;
    logic clr_seen, cpu_tick, f_cpu, f_ppu, f_phase;
    logic [3:0] ref_sel;

    mon_state_e           state_q, state_d;
    logic [3:0]           good_q, good_d, ref_q, ref_d, phase_offset_q, phase_offset_d;
    logic                 ref_vld_q, ref_vld_d, late_pend_q, late_pend_d, locked_q, locked_d;
    logic                 err_cpu_q, err_cpu_d, err_ppu_q, err_ppu_d, err_ph_q, err_ph_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    en_period_checker #(.DIV(CPU_CLK_DIV), .CNT_W(CPU_CNT_W)) u_cpu_chk (
        .clk(clk_mst), .rst_n(rst_mst_n), .en(clk_en_cpu), .clr_seen(clr_seen),
        .cnt(cpu_cnt), .seen(cpu_seen), .early(cpu_early), .late(cpu_late)
    );

    en_period_checker #(.DIV(PPU_CLK_DIV), .CNT_W(PPU_CNT_W)) u_ppu_chk (
        .clk(clk_mst), .rst_n(rst_mst_n), .en(clk_en_ppu), .clr_seen(clr_seen),
        .cnt(ppu_cnt), .seen(ppu_seen), .early(ppu_early), .late(ppu_late)
    );

    // A CPU pulse cycle is exactly where the CPU counter restarts at zero.
    assign cpu_tick = (cpu_cnt == '0);

    always_comb begin
        state_d        = state_q;
        good_d         = good_q;
        ref_d          = ref_q;
        ref_vld_d      = ref_vld_q;
        late_pend_d    = late_pend_q;
        phase_offset_d = phase_offset_q;
        err_cpu_d      = mon_clear ? 1'b0 : err_cpu_q;
        err_ppu_d      = mon_clear ? 1'b0 : err_ppu_q;
        err_ph_d       = mon_clear ? 1'b0 : err_ph_q;
        err_cnt_d      = mon_clear ? '0 : err_cnt_q;
        clr_seen       = 1'b0;
        ref_sel        = ref_vld_q ? ref_q : ppu_cnt;
        f_cpu          = cpu_early | cpu_late;
        f_ppu          = ppu_early | ppu_late;
        f_phase        = cpu_tick && (ppu_cnt != ref_q);

        unique case (state_q)
            ST_ACQUIRE: begin
                if (cpu_seen && ppu_seen) begin
                    state_d     = ST_TRAIN;
                    good_d      = '0;
                    ref_vld_d   = 1'b0;
                    late_pend_d = 1'b0;
                end
            end
            ST_TRAIN: begin
                late_pend_d = !cpu_tick && (late_pend_q || cpu_late || ppu_late);
                if (cpu_tick) begin
                    ref_d     = ref_sel;
                    ref_vld_d = 1'b1;
                    if (!f_cpu && !f_ppu && !late_pend_q && (ppu_cnt == ref_sel)) begin
                        good_d = good_q + 1'b1;
                        if (good_q == GOOD_LAST) begin
                            state_d        = ST_LOCKED;
                            phase_offset_d = ref_sel;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (f_cpu || f_ppu) begin
                    good_d = '0;
                end
            end
            ST_LOCKED: begin
                // Every fault seen this cycle is flagged, but counts as one event.
                if (f_cpu || f_ppu || f_phase) begin
                    err_cpu_d = err_cpu_d | f_cpu;
                    err_ppu_d = err_ppu_d | f_ppu;
                    err_ph_d  = err_ph_d | f_phase;
                    if (err_cnt_d != '1)
                        err_cnt_d = err_cnt_d + 1'b1;
                    state_d  = ST_ACQUIRE;
                    clr_seen = 1'b1;
                end
            end
            default: state_d = ST_ACQUIRE;
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_mst) begin
        if (!rst_mst_n) begin
            state_q        <= ST_ACQUIRE;
            good_q         <= '0;
            ref_q          <= '0;
            ref_vld_q      <= 1'b0;
            late_pend_q    <= 1'b0;
            phase_offset_q <= '0;
            locked_q       <= 1'b0;
            err_cpu_q      <= 1'b0;
            err_ppu_q      <= 1'b0;
            err_ph_q       <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            good_q         <= good_d;
            ref_q          <= ref_d;
            ref_vld_q      <= ref_vld_d;
            late_pend_q    <= late_pend_d;
            phase_offset_q <= phase_offset_d;
            locked_q       <= locked_d;
            err_cpu_q      <= err_cpu_d;
            err_ppu_q      <= err_ppu_d;
            err_ph_q       <= err_ph_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign locked         = locked_q;
    assign err_cpu_period = err_cpu_q;
    assign err_ppu_period = err_ppu_q;
    assign err_phase      = err_ph_q;
    assign err_count      = err_cnt_q;
    assign phase_offset   = phase_offset_q;

endmodule
